// File: rtl/dpq_frame_fetch_pkg.sv
// Shared definitions for the dpq frame fetcher: state encoding, header layout
// and default limits.
package dpq_frame_fetch_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_REQ  = 3'd1;
    localparam state_t ST_HDR  = 3'd2;
    localparam state_t ST_DATA = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_MSB = 15;

    localparam int MAX_LEN_DEF     = 1518;
    localparam int GNT_TIMEOUT_DEF = 1023;

    // Byte length to 32-bit word count, rounded up.
    function automatic logic [15:0] len_to_words(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd3;
        return {1'b0, sum[16:2]};
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dpq_fetch_skid.sv
// Two-entry FIFO that absorbs read data still in flight when the crossbar
// stalls. The caller guarantees it never pushes when full or pops when empty.
module dpq_fetch_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] data_in,
    input  logic         pop,
    output logic [W-1:0] data_out,
    output logic [1:0]   count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [W-1:0] entry_reg;
            logic         sel;
            assign sel = (wr_ptr_reg == 1'(gi));
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    entry_reg <= '0;
                end else if (push && sel) begin
                    entry_reg <= data_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign data_out = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
    assign count    = count_reg;

endmodule

// File: rtl/dpq_frame_fetch.sv
// Fetches one queued frame from the input buffer and streams it to the
// crossbar: request, header read, paced data reads, then done handshake.
module dpq_frame_fetch
    import dpq_frame_fetch_pkg::*;
#(
    parameter int ADR_W       = 16,
    parameter int MAX_LEN     = MAX_LEN_DEF,
    parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adr_valid,
    input  logic [ADR_W-1:0] start_adr,
    input  logic [7:0]       T_q,
    output logic             transmit_done,
    output logic             buf_rd_en,
    output logic [ADR_W-1:0] buf_rd_adr,
    input  logic [31:0]      buf_rd_data,
    output logic [7:0]       xbar_req,
    input  logic             xbar_gnt,
    output logic             xbar_valid,
    input  logic             xbar_ready,
    output logic [31:0]      xbar_data,
    output logic             xbar_sof,
    output logic             xbar_eof,
    output logic [1:0]       xbar_nbytes,
    output logic [15:0]      frame_cnt,
    output logic [7:0]       drop_cnt
);

    state_t           state_reg;
    logic [ADR_W-1:0] adr_reg;
    logic [7:0]       mask_reg;
    logic [15:0]      wait_cnt_reg;
    logic             hdr_pend_reg;
    logic             data_pend_reg;
    logic [1:0]       len_lo_reg;
    logic [15:0]      words_reg;
    logic [15:0]      rd_cnt_reg;
    logic [15:0]      tx_cnt_reg;
    logic [15:0]      frame_cnt_reg;
    logic [7:0]       drop_cnt_reg;

    logic [15:0] hdr_len;
    logic [15:0] hdr_words;
    logic        hdr_ok;
    logic        rd_hdr, rd_first, rd_data;
    logic        room;
    logic        xfer, last_xfer;
    logic        skid_push, skid_pop, skid_empty;
    logic [31:0] skid_data;
    logic [1:0]  skid_count;

    assign hdr_len   = buf_rd_data[HDR_LEN_MSB:HDR_LEN_LSB];
    assign hdr_words = len_to_words(hdr_len);
    assign hdr_ok    = (hdr_len != 16'd0) && ({16'd0, hdr_len} <= 32'(MAX_LEN));

    dpq_fetch_skid #(.W(32)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .push     (skid_push),
        .data_in  (buf_rd_data),
        .pop      (skid_pop),
        .data_out (skid_data),
        .count    (skid_count)
    );

    // A word arriving into an empty skid is shown directly (bypass) so the
    // first word appears the cycle its read data returns; if it is not
    // accepted it is pushed and re-presented from the skid unchanged.
    always_comb begin
        skid_empty = (skid_count == 2'd0);
        room       = (skid_count == 2'd0) || ((skid_count == 2'd1) && !data_pend_reg);
        rd_hdr     = (state_reg == ST_HDR) && !hdr_pend_reg;
        rd_first   = (state_reg == ST_HDR) && hdr_pend_reg && hdr_ok;
        rd_data    = (state_reg == ST_DATA) && (rd_cnt_reg < words_reg) && room;

        buf_rd_en  = rd_hdr || rd_first || rd_data;
        buf_rd_adr = '0;
        if (rd_hdr) begin
            buf_rd_adr = adr_reg;
        end else if (rd_first || rd_data) begin
            buf_rd_adr = adr_reg + ADR_W'(rd_cnt_reg) + ADR_W'(1);
        end

        xbar_valid  = (state_reg == ST_DATA) && (!skid_empty || data_pend_reg);
        xbar_data   = xbar_valid ? (skid_empty ? buf_rd_data : skid_data) : 32'd0;
        xbar_sof    = xbar_valid && (tx_cnt_reg == 16'd0);
        xbar_eof    = xbar_valid && (tx_cnt_reg == words_reg - 16'd1);
        xbar_nbytes = xbar_eof ? len_lo_reg : 2'd0;

        xfer      = xbar_valid && xbar_ready;
        last_xfer = xfer && xbar_eof;
        skid_pop  = xbar_ready && !skid_empty && (state_reg == ST_DATA);
        skid_push = data_pend_reg && !(skid_empty && xbar_ready);

        xbar_req = 8'h00;
        if (((state_reg == ST_REQ) && (mask_reg != 8'h00)) ||
            (state_reg == ST_HDR) || (state_reg == ST_DATA)) begin
            xbar_req = mask_reg;
        end

        transmit_done = (state_reg == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            adr_reg       <= '0;
            mask_reg      <= 8'h00;
            wait_cnt_reg  <= 16'd0;
            hdr_pend_reg  <= 1'b0;
            data_pend_reg <= 1'b0;
            len_lo_reg    <= 2'd0;
            words_reg     <= 16'd0;
            rd_cnt_reg    <= 16'd0;
            tx_cnt_reg    <= 16'd0;
            frame_cnt_reg <= 16'd0;
            drop_cnt_reg  <= 8'd0;
        end else begin
            data_pend_reg <= rd_first || rd_data;
            case (state_reg)
                ST_IDLE: begin
                    if (adr_valid && !transmit_done) begin
                        adr_reg      <= start_adr;
                        mask_reg     <= T_q;
                        wait_cnt_reg <= 16'd0;
                        state_reg    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mask_reg == 8'h00) begin
                        state_reg    <= ST_DONE;
                        drop_cnt_reg <= sat_inc8(drop_cnt_reg);
                    end else if (xbar_gnt) begin
                        state_reg    <= ST_HDR;
                        hdr_pend_reg <= 1'b0;
                        rd_cnt_reg   <= 16'd0;
                        tx_cnt_reg   <= 16'd0;
                    end else if (wait_cnt_reg == 16'(GNT_TIMEOUT - 1)) begin
                        state_reg    <= ST_DONE;
                        drop_cnt_reg <= sat_inc8(drop_cnt_reg);
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    end
                end
                ST_HDR: begin
                    if (!hdr_pend_reg) begin
                        hdr_pend_reg <= 1'b1;
                    end else begin
                        hdr_pend_reg <= 1'b0;
                        if (hdr_ok) begin
                            words_reg  <= hdr_words;
                            len_lo_reg <= hdr_len[1:0];
                            rd_cnt_reg <= 16'd1;
                            state_reg  <= ST_DATA;
                        end else begin
                            state_reg    <= ST_DONE;
                            drop_cnt_reg <= sat_inc8(drop_cnt_reg);
                        end
                    end
                end
                ST_DATA: begin
                    if (rd_data) rd_cnt_reg <= rd_cnt_reg + 16'd1;
                    if (xfer)    tx_cnt_reg <= tx_cnt_reg + 16'd1;
                    if (last_xfer) begin
                        state_reg     <= ST_DONE;
                        frame_cnt_reg <= frame_cnt_reg + 16'd1;
                    end
                end
                ST_DONE: begin
                    if (!adr_valid) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign frame_cnt = frame_cnt_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule
